riscv_run_ctrl: RTL and testbench
=================================

RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 SHALL have parameter GPIO_W, default 8, width of the monitored GPIO bus.
REQ-002 SHALL have parameter RST_CYCLES, default 10, core reset hold length in clk cycles (minimum 1).
REQ-003 SHALL have parameter MAX_CYCLES, default 1000, run-cycle limit before timeout (minimum 2).
REQ-004 SHALL have parameter CNT_W, default 32, cycle counter width.
REQ-005 SHALL have parameters PASS_CODE, default 8'h01, and FAIL_CODE, default 8'hFF, the GPIO completion signatures (GPIO_W bits).
REQ-006 SHALL have parameter HB_CYCLES, default 256, heartbeat window (used only under REQ-028).
REQ-007 clk  input  1  single clock; all logic on the rising edge.
REQ-008 rstn  input  1  asynchronous active-low reset.
REQ-009 gpio_i  input  GPIO_W  core GPIO output under observation.
REQ-010 restart  input  1  single-cycle request to re-run the core.
REQ-011 core_rstn  output  1  registered active-low reset driven to the core.
REQ-012 running  output  1  high while in RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 pass, fail, timeout  output  1 each  sticky completion cause flags.
REQ-015 cycle_cnt  output  CNT_W  cycles elapsed in RUN.

Function
REQ-016 SHALL implement a three-state FSM: HOLD, RUN, DONE; HOLD is entered from reset.
REQ-017 HOLD: core_rstn=0; a hold counter counts RST_CYCLES rising edges, then the FSM moves to RUN and core_rstn goes high on that same edge.
REQ-018 RUN: cycle_cnt SHALL start at 0 on the first RUN cycle and increment by 1 per cycle, saturating at all-ones.
REQ-019 gpio_i SHALL be registered once; all comparisons use the registered value (one-cycle detection latency).
REQ-020 RUN: registered gpio == FAIL_CODE -> DONE with fail=1; == PASS_CODE -> DONE with pass=1; cycle_cnt == MAX_CYCLES-1 -> DONE with timeout=1.
REQ-021 Simultaneous causes: priority fail > pass > timeout; exactly one cause flag SHALL be set per run.
REQ-022 DONE: core_rstn stays 1 (core free-running); cycle_cnt, pass, fail and timeout frozen.
REQ-023 restart=1 in any state SHALL clear all flags and cycle_cnt, drive core_rstn=0 and enter HOLD with the hold counter reloaded on the next edge.
REQ-024 If PASS_CODE == FAIL_CODE, a match SHALL report fail.
REQ-025 running = (state==RUN); done = (state==DONE); both registered, with no glitch paths from gpio_i.

Reset
REQ-026 rstn low SHALL immediately force: state=HOLD, core_rstn=0, running=0, done=0, pass=0, fail=0, timeout=0, cycle_cnt=0, hold counter=0, registered gpio=0.
REQ-027 Deassertion of rstn mid-run SHALL restart the full HOLD sequence; no state is retained.

Configuration
REQ-028 With RUN_CTRL_HEARTBEAT_EN defined: in RUN, if the registered gpio is unchanged for HB_CYCLES consecutive cycles, the FSM SHALL enter DONE with fail=1 (same priority as fail); the heartbeat counter clears on any gpio change and on restart.
REQ-029 Without RUN_CTRL_HEARTBEAT_EN: no heartbeat counter is instantiated, HB_CYCLES is ignored, and a static gpio never causes completion.

Verification
REQ-030 Defaults, rstn low 3 cycles then high -> core_rstn rises exactly 10 rising edges after rstn deassertion; running=1 on the same edge.
REQ-031 gpio_i=8'h01 driven at RUN cycle 20 -> done=1, pass=1 one cycle later; cycle_cnt frozen at 21.
REQ-032 gpio_i held 8'h00 -> timeout=1, done=1 with cycle_cnt=999; pass=fail=0.
REQ-033 PASS_CODE=FAIL_CODE=8'h55, gpio_i=8'h55 -> fail=1, pass=0.
REQ-034 restart pulse in DONE, then rstn pulsed low mid-RUN -> flags clear, core_rstn=0 and HOLD re-entered each time, followed by a fresh 10-cycle hold.
REQ-035 RUN_CTRL_HEARTBEAT_EN defined, HB_CYCLES=16, gpio_i static from RUN entry -> fail=1 after 16 static cycles; undefined -> no completion before timeout.

Source files
------------

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: core reset sequencer and run monitor (HOLD -> RUN -> DONE).
// Optional heartbeat watchdog enabled by defining RUN_CTRL_HEARTBEAT_EN.
module riscv_run_ctrl #(
    parameter int                GPIO_W     = 8,
    parameter int                RST_CYCLES = 10,
    parameter int                MAX_CYCLES = 1000,
    parameter int                CNT_W      = 32,
    parameter logic [GPIO_W-1:0] PASS_CODE  = GPIO_W'(8'h01),
    parameter logic [GPIO_W-1:0] FAIL_CODE  = GPIO_W'(8'hFF),
    parameter int                HB_CYCLES  = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [GPIO_W-1:0] gpio_i,
    input  logic              restart,
    output logic              core_rstn,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_CYCLES - 1);

    if (RST_CYCLES < 1 || MAX_CYCLES < 2 || HB_CYCLES < 1) begin : g_param_chk
        $error("riscv_run_ctrl: illegal parameter value");
    end

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [GPIO_W-1:0] gpio_q;
    logic              hb_hit;
    logic              fail_hit;
    logic              pass_hit;
    logic              to_hit;

    // Single register stage on the observed bus; all decisions use gpio_q
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) gpio_q <= '0;
        else       gpio_q <= gpio_i;
    end

`ifdef RUN_CTRL_HEARTBEAT_EN
    localparam int HBW = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;
    localparam logic [HBW-1:0] HB_LAST = HBW'(HB_CYCLES - 1);

    logic [GPIO_W-1:0] gpio_p;
    logic [HBW-1:0]    hb_cnt;
    logic              gpio_same;

    assign gpio_same = (gpio_q == gpio_p);
    assign hb_hit    = (state == RUN) && gpio_same && (hb_cnt == HB_LAST);

    // Counts consecutive RUN cycles with an unchanged registered gpio
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpio_p <= '0;
            hb_cnt <= '0;
        end else begin
            gpio_p <= gpio_q;
            if (restart || state != RUN || !gpio_same) hb_cnt <= '0;
            else if (hb_cnt != HB_LAST)                hb_cnt <= hb_cnt + 1'b1;
        end
    end
`else
    assign hb_hit = 1'b0;
`endif

    // Fail outranks pass, so equal codes report fail
    assign fail_hit = (gpio_q == FAIL_CODE) || hb_hit;
    assign pass_hit = (gpio_q == PASS_CODE);
    assign to_hit   = (cycle_cnt == RUN_LAST);

    // Main sequencer with registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            core_rstn <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
        end else if (restart) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            core_rstn <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        core_rstn <= 1'b1;
                        running   <= 1'b1;
                        cycle_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (fail_hit || pass_hit || to_hit) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        fail    <= fail_hit;
                        pass    <= !fail_hit && pass_hit;
                        timeout <= !fail_hit && !pass_hit;
                    end else if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// tb_riscv_run_ctrl: directed vectors for the run controller.
// u0 uses default codes, u1 uses PASS_CODE = FAIL_CODE = 8'h55.
module tb_riscv_run_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        restart;
    logic [7:0]  gpio0;
    logic [7:0]  gpio1;

    logic        core_rstn0, running0, done0, pass0, fail0, timeout0;
    logic [31:0] cnt0;
    logic        core_rstn1, running1, done1, pass1, fail1, timeout1;
    logic [31:0] cnt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    riscv_run_ctrl u0 (
        .clk       (clk),
        .rstn      (rstn),
        .gpio_i    (gpio0),
        .restart   (restart),
        .core_rstn (core_rstn0),
        .running   (running0),
        .done      (done0),
        .pass      (pass0),
        .fail      (fail0),
        .timeout   (timeout0),
        .cycle_cnt (cnt0)
    );

    riscv_run_ctrl #(
        .PASS_CODE (8'h55),
        .FAIL_CODE (8'h55)
    ) u1 (
        .clk       (clk),
        .rstn      (rstn),
        .gpio_i    (gpio1),
        .restart   (restart),
        .core_rstn (core_rstn1),
        .running   (running1),
        .done      (done1),
        .pass      (pass1),
        .fail      (fail1),
        .timeout   (timeout1),
        .cycle_cnt (cnt1)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ten edges of hold: core_rstn low through edge 9, high on edge 10
    task automatic hold_seq(input string tag);
        repeat (9) @(posedge clk);
        #1;
        check({tag, "_hold9_crst"}, core_rstn0, 1'b0);
        check({tag, "_hold9_run"}, running0, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_hold10_crst"}, core_rstn0, 1'b1);
        check({tag, "_hold10_run"}, running0, 1'b1);
        check({tag, "_hold10_cnt"}, cnt0, 0);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        check("rs_crst", core_rstn0, 1'b0);
        check("rs_done", done0, 1'b0);
        check("rs_flags", {pass0, fail0, timeout0}, 3'b000);
        check("rs_cnt", cnt0, 0);
        check("rs_u1_flags", {pass1, fail1, timeout1}, 3'b000);
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        int n;
        rstn    = 1'b0;
        restart = 1'b0;
        gpio0   = 8'h00;
        gpio1   = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_crst", core_rstn0, 1'b0);
        check("rst_run_done", {running0, done0}, 2'b00);
        check("rst_flags", {pass0, fail0, timeout0}, 3'b000);
        check("rst_cnt", cnt0, 0);
        rstn = 1'b1;

        hold_seq("init");
        check("u1_run", running1, 1'b1);

        repeat (20) @(posedge clk);
        #1;
        check("pass_cnt20", cnt0, 20);
        gpio0 = 8'h01;
        gpio1 = 8'h55;
        @(posedge clk);
        #1;
        check("pass_cnt21", cnt0, 21);
        check("pass_notyet", done0, 1'b0);
        @(posedge clk);
        #1;
        check("pass_done", {running0, done0}, 2'b01);
        check("pass_flags", {pass0, fail0, timeout0}, 3'b100);
        check("pass_cnt", cnt0, 21);
        check("eq_flags", {pass1, fail1, timeout1}, 3'b010);
        check("eq_done", done1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("done_frozen", cnt0, 21);
        check("done_crst", core_rstn0, 1'b1);
        check("done_flags", {pass0, fail0, timeout0}, 3'b100);

        gpio0 = 8'h00;
        gpio1 = 8'h00;
        pulse_restart();
        hold_seq("rs");

        n = 0;
        while (!done0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("to_latency", n, 1000);
        check("to_flags", {pass0, fail0, timeout0}, 3'b001);
        check("to_cnt", cnt0, 999);
        check("to_u1_flags", {pass1, fail1, timeout1}, 3'b001);

        pulse_restart();
        hold_seq("rs2");
        repeat (5) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_crst", core_rstn0, 1'b0);
        check("arst_run", running0, 1'b0);
        check("arst_cnt", cnt0, 0);
        @(negedge clk);
        rstn = 1'b1;
        hold_seq("arst");

        repeat (7) @(posedge clk);
        #1;
        gpio0 = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("fail_flags", {pass0, fail0, timeout0}, 3'b010);
        check("fail_cnt", cnt0, 8);
        check("fail_done", done0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
